// File: rtl/parity_frame_ctrl_if.sv
// Parallel-in / serial-out bus for the parity frame controller.
// The master side is the producer and link monitor; the slave side is the controller.
interface parity_frame_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             odd_sel;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;

    modport master (
        output in_data, in_valid, odd_sel,
        input  in_ready, sout, sout_valid, sout_last
    );

    modport slave (
        input  in_data, in_valid, odd_sel,
        output in_ready, sout, sout_valid, sout_last
    );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Serializes a parallel word LSB-first, appends an even/odd parity bit,
// tracks running parity and counts completed frames.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no frame in flight, serial outputs quiet, ready for a word
// S_SHIFT | data bits on sout, one per cycle, bit_cnt_q counts down
// S_PAR   | parity bit on sout (sout_last=1); may accept the next word
module parity_frame_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    parity_frame_ctrl_if.slave bus,
    input  logic               abort,
    output logic               par_acc,
    output logic [CNT_W-1:0]   frame_cnt
);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_LOAD = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               odd_q, odd_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               sout_q, sout_d;
    logic               sout_valid_q, sout_valid_d;
    logic               sout_last_q, sout_last_d;
    logic               par_acc_q, par_acc_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic busy;
    logic kill;
    logic accept;

    assign bus.in_ready   = (state_q == S_IDLE) || (state_q == S_PAR);
    assign busy           = (state_q == S_SHIFT) || (state_q == S_PAR);
    // abort only matters mid-frame, and in PAR it wins over a pending word
    assign kill           = abort && busy;
    assign accept         = bus.in_valid && bus.in_ready && !kill;

    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.sout_last  = sout_last_q;
    assign par_acc        = par_acc_q;
    assign frame_cnt      = frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sh_q         <= '0;
            odd_q        <= 1'b0;
            bit_cnt_q    <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
            par_acc_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            odd_q        <= odd_d;
            bit_cnt_q    <= bit_cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
            par_acc_q    <= par_acc_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SHIFT;
            S_SHIFT: begin
                if (kill)                   state_d = S_IDLE;
                else if (bit_cnt_q == '0)   state_d = S_PAR;
            end
            S_PAR:   state_d = accept ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Computes the registered serial outputs for the cycle after this edge.
    always_comb begin
        sh_d         = sh_q;
        odd_d        = odd_q;
        bit_cnt_d    = bit_cnt_q;
        par_acc_d    = par_acc_q;
        frame_cnt_d  = frame_cnt_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        sout_last_d  = 1'b0;
        case (state_q)
            S_SHIFT: begin
                if (kill) begin
                    par_acc_d = 1'b0;
                end else begin
                    // sh_q[0] is the bit currently on sout
                    par_acc_d    = par_acc_q ^ sh_q[0];
                    sh_d         = sh_q >> 1;
                    sout_valid_d = 1'b1;
                    if (bit_cnt_q == '0) begin
                        sout_d      = par_acc_q ^ sh_q[0] ^ odd_q;
                        sout_last_d = 1'b1;
                    end else begin
                        sout_d    = sh_q[1];
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end
            end
            S_PAR: begin
                if (kill) par_acc_d   = 1'b0;
                else      frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
        if (accept) begin
            sh_d         = bus.in_data;
            odd_d        = bus.odd_sel;
            bit_cnt_d    = LAST_LOAD;
            par_acc_d    = 1'b0;
            sout_d       = bus.in_data[0];
            sout_valid_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: two instances (16-bit and 2-bit frame counters) share
// stimulus and are compared cycle by cycle against a frame-queue reference model.
`timescale 1ns/1ps
module tb_parity_frame_ctrl;
    localparam int WIDTH = 8;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic [WIDTH-1:0] in_data  = '0;
    logic             in_valid = 1'b0;
    logic             odd_sel  = 1'b0;
    logic             abort    = 1'b0;
    logic             par_a, par_b;
    logic [15:0]      cnt_a;
    logic [1:0]       cnt_b;
    int               tests = 0;
    int               fails = 0;

    parity_frame_ctrl_if #(.WIDTH(WIDTH)) bus_a ();
    parity_frame_ctrl_if #(.WIDTH(WIDTH)) bus_b ();

    assign bus_a.in_data  = in_data;
    assign bus_a.in_valid = in_valid;
    assign bus_a.odd_sel  = odd_sel;
    assign bus_b.in_data  = in_data;
    assign bus_b.in_valid = in_valid;
    assign bus_b.odd_sel  = odd_sel;

    parity_frame_ctrl #(.WIDTH(WIDTH), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .abort(abort), .par_acc(par_a), .frame_cnt(cnt_a)
    );
    parity_frame_ctrl #(.WIDTH(WIDTH), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .abort(abort), .par_acc(par_b), .frame_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    // Reference model: the frame is a list of {bit, last, parity-so-far} entries
    // built on accept; one entry is presented per cycle.
    bit          m_valid = 0, m_sout = 0, m_last = 0, m_par = 0, m_acc = 0;
    int unsigned m_cnt = 0;
    logic [2:0]  pend[$];

    function automatic bit m_ready();
        return !m_valid || m_last;
    endfunction

    function automatic logic [22:0] mdl();
        return {m_valid, m_sout, m_last, m_par, m_ready(), m_cnt[15:0], m_cnt[1:0]};
    endfunction

    function automatic logic [22:0] obs();
        return {bus_a.sout_valid, bus_a.sout, bus_a.sout_last, par_a, bus_a.in_ready, cnt_a, cnt_b};
    endfunction

    task automatic model_step();
        bit busy, in_par, ready, ab, p;
        logic [2:0] e;
        busy   = m_valid;
        in_par = m_valid && m_last;
        ready  = m_ready();
        m_acc  = 0;
        if (rst) begin
            pend.delete();
            {m_valid, m_sout, m_last, m_par} = 4'b0;
            m_cnt = 0;
            return;
        end
        ab = abort && busy;
        if (in_par && !ab) m_cnt++;
        if (ab) begin
            pend.delete();
            {m_valid, m_sout, m_last, m_par} = 4'b0;
        end else begin
            if (in_valid && ready) begin
                m_acc = 1;
                pend.delete();
                p = 0;
                for (int i = 0; i < WIDTH; i++) begin
                    pend.push_back({in_data[i], 1'b0, p});
                    p = p ^ in_data[i];
                end
                pend.push_back({p ^ odd_sel, 1'b1, p});
            end
            if (pend.size() > 0) begin
                e = pend.pop_front();
                m_valid = 1; m_sout = e[2]; m_last = e[1]; m_par = e[0];
            end else begin
                m_valid = 0; m_sout = 0; m_last = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; abort = 0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (obs() !== mdl()) begin
                fails++; $display("FAIL reset cyc %0d: got %b exp %b", c, obs(), mdl());
            end
            tests++;
        end
        if (cnt_a !== 16'd0 || bus_a.in_ready !== 1'b1 || bus_a.sout_valid !== 1'b0) begin
            fails++; $display("FAIL reset_vals: cnt=%0d ready=%b valid=%b exp 0/1/0", cnt_a, bus_a.in_ready, bus_a.sout_valid);
        end
        tests++;
        rst = 0;
    endtask

    task automatic test_frame(input logic [7:0] d, input logic odd, input logic [8:0] exp_bits, input string name);
        logic [8:0]  cap;
        int          n, lo;
        int unsigned c0;
        cap = '0; n = 0; lo = 0; c0 = m_cnt;
        in_data = d; odd_sel = odd; in_valid = 1;
        for (int c = 0; c < WIDTH + 3; c++) begin
            cycle();
            if (obs() !== mdl()) begin
                fails++; $display("FAIL %s cyc %0d: got %b exp %b", name, c, obs(), mdl());
            end
            tests++;
            if (bus_a.sout_valid === 1'b1 && n < 9) begin cap[n] = bus_a.sout; n++; end
            if (bus_a.in_ready === 1'b0) lo++;
            in_valid = 0; in_data = WIDTH'($urandom); odd_sel = 1'($urandom);
        end
        if (cap !== exp_bits || n != 9) begin
            fails++; $display("FAIL %s bits: got %b (%0d) exp %b (9)", name, cap, n, exp_bits);
        end
        tests++;
        if (lo != WIDTH) begin
            fails++; $display("FAIL %s ready_low: got %0d exp %0d", name, lo, WIDTH);
        end
        tests++;
        if (cnt_a !== 16'(c0 + 1)) begin
            fails++; $display("FAIL %s frame_cnt: got %0d exp %0d", name, cnt_a, c0 + 1);
        end
        tests++;
    endtask

    task automatic test_back_to_back();
        int          acc_n, run, best, np;
        logic [1:0]  pb;
        int unsigned c0;
        acc_n = 0; run = 0; best = 0; np = 0; pb = '0; c0 = m_cnt;
        in_data = 8'hFF; odd_sel = 0; in_valid = 1;
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (obs() !== mdl()) begin
                fails++; $display("FAIL b2b cyc %0d: got %b exp %b", c, obs(), mdl());
            end
            tests++;
            if (m_acc) begin
                acc_n++;
                if (acc_n == 1) in_data = 8'h01;
                else            in_valid = 0;
            end
            if (bus_a.sout_valid === 1'b1) begin run++; if (run > best) best = run; end
            else run = 0;
            if (bus_a.sout_last === 1'b1 && np < 2) begin pb[np] = bus_a.sout; np++; end
        end
        in_valid = 0;
        if (acc_n != 2) begin
            fails++; $display("FAIL b2b accepts: got %0d exp 2 (timeout)", acc_n);
        end
        tests++;
        if (best != 18) begin
            fails++; $display("FAIL b2b contiguous: got %0d exp 18", best);
        end
        tests++;
        if (pb !== 2'b10 || np != 2) begin
            fails++; $display("FAIL b2b parities: got %b exp 10", pb);
        end
        tests++;
        if (cnt_a !== 16'(c0 + 2)) begin
            fails++; $display("FAIL b2b frame_cnt: got %0d exp %0d", cnt_a, c0 + 2);
        end
        tests++;
    endtask

    task automatic test_abort();
        int unsigned c0;
        c0 = m_cnt;
        for (int c = 0; c < 28; c++) begin
            in_valid = (c == 0) || (c == 5) || (c == 14) || (c == 15);
            in_data  = (c == 0) ? 8'hA5 : (c == 5) ? 8'h3C : (c >= 14) ? 8'h99 : WIDTH'($urandom);
            odd_sel  = 1'($urandom);
            abort    = (c == 4) || (c == 14) || (c == 26);
            cycle();
            if (obs() !== mdl()) begin
                fails++; $display("FAIL abort cyc %0d: got %b exp %b", c, obs(), mdl());
            end
            tests++;
            if (c == 4 || c == 14) begin
                if (bus_a.sout_valid !== 1'b0 || bus_a.in_ready !== 1'b1 || cnt_a !== 16'(c0)) begin
                    fails++; $display("FAIL abort_effect cyc %0d: valid=%b ready=%b cnt=%0d exp 0/1/%0d", c, bus_a.sout_valid, bus_a.in_ready, cnt_a, c0);
                end
                tests++;
            end
        end
        abort = 0; in_valid = 0;
        if (cnt_a !== 16'(c0 + 1)) begin
            fails++; $display("FAIL abort frame_cnt: got %0d exp %0d", cnt_a, c0 + 1);
        end
        tests++;
    endtask

    task automatic test_reset_mid();
        in_data = 8'h0F | WIDTH'($urandom); odd_sel = 1'($urandom); in_valid = 1;
        for (int c = 0; c < 8; c++) begin
            rst = (c == 4);
            cycle();
            in_valid = 0;
            if (obs() !== mdl()) begin
                fails++; $display("FAIL rst_mid cyc %0d: got %b exp %b", c, obs(), mdl());
            end
            tests++;
            if (c == 4) begin
                if ({bus_a.sout, bus_a.sout_valid, bus_a.sout_last, par_a, cnt_a, cnt_b} !== 22'd0 || bus_a.in_ready !== 1'b1) begin
                    fails++; $display("FAIL rst_mid_vals: got %b ready=%b exp all zero, ready 1", {bus_a.sout, bus_a.sout_valid, bus_a.sout_last, par_a, cnt_a, cnt_b}, bus_a.in_ready);
                end
                tests++;
            end
        end
        rst = 0;
    endtask

    task automatic test_wrap();
        logic [9:0] seq;
        logic [1:0] prev;
        int         n, accs;
        seq = '0; n = 0; accs = 0;
        rst = 1; cycle(); rst = 0;
        prev = cnt_b;
        in_valid = 1;
        for (int c = 0; c < 60; c++) begin
            in_data = WIDTH'($urandom); odd_sel = 1'($urandom);
            cycle();
            if (obs() !== mdl()) begin
                fails++; $display("FAIL wrap cyc %0d: got %b exp %b", c, obs(), mdl());
            end
            tests++;
            if (cnt_b !== prev) begin
                if (n < 5) seq[2*n +: 2] = cnt_b;
                n++; prev = cnt_b;
            end
            if (m_acc) accs++;
            if (accs == 5) in_valid = 0;
        end
        in_valid = 0;
        if (seq !== 10'b01_00_11_10_01 || n != 5) begin
            fails++; $display("FAIL wrap seq: got %b (%0d changes) exp 0100111001 (5)", seq, n);
        end
        tests++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(2) != 0);
            in_data  = WIDTH'($urandom);
            odd_sel  = 1'($urandom);
            abort    = ($urandom_range(11) == 0);
            rst      = ($urandom_range(99) == 0);
            cycle();
            if (obs() !== mdl()) begin
                fails++; $display("FAIL random cyc %0d: got %b exp %b", c, obs(), mdl());
            end
            tests++;
        end
        rst = 0; abort = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_frame(8'hB4, 1'b0, 9'h0B4, "b4_even");
        test_frame(8'h07, 1'b1, 9'h007, "x07_odd");
        test_frame(8'h07, 1'b0, 9'h107, "x07_even");
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
